// File: rtl/mm2s_cmd_sched_pkg.sv
// -----------------------------------------------------------------------------
// mm2s_cmd_sched_pkg
// Shared definitions for the DataMover command schedulers (MM2S and S2MM):
//   - state_t       : scheduler FSM state encoding
//   - CMD_* offsets : bit positions of the 72-bit DataMover command word
//   - TAG_W         : command tag width ({owner, sequence count})
//   - build_cmd()   : assembles a command word from its fields
// -----------------------------------------------------------------------------
package mm2s_cmd_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int CMD_W         = 72;
    localparam int CMD_BTT_LSB   = 0;
    localparam int CMD_BTT_W     = 23;
    localparam int CMD_TYPE_BIT  = 23;
    localparam int CMD_EOF_BIT   = 30;
    localparam int CMD_SADDR_LSB = 32;
    localparam int CMD_SADDR_W   = 32;
    localparam int CMD_TAG_LSB   = 64;
    localparam int TAG_W         = 4;
    localparam int SEQ_W         = 3;

    // INCR burst type and EOF are always set; DRR, DSA and the reserved
    // upper nibble stay zero.
    function automatic logic [CMD_W-1:0] build_cmd(
        input logic [CMD_SADDR_W-1:0] saddr,
        input logic [CMD_BTT_W-1:0]   btt,
        input logic [TAG_W-1:0]       tag
    );
        logic [CMD_W-1:0] v;
        v = {CMD_W{1'b0}};
        v[CMD_BTT_LSB +: CMD_BTT_W]     = btt;
        v[CMD_TYPE_BIT]                 = 1'b1;
        v[CMD_EOF_BIT]                  = 1'b1;
        v[CMD_SADDR_LSB +: CMD_SADDR_W] = saddr;
        v[CMD_TAG_LSB +: TAG_W]         = tag;
        return v;
    endfunction

endpackage

// File: rtl/mm2s_cmd_sched_arb.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. On a tie the requester that was not granted
// last wins. The last-grant record only moves when the caller latches a
// winner (i_update), so a request that is seen but not taken does not
// disturb fairness.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_req[1:0]   : request vector
//   i_update     : winner was latched this cycle
//   o_valid      : at least one request pending
//   o_idx        : index of the winning requester
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic       o_valid,
    output logic       o_idx
);

    logic r_last;

    // Winner selection: favour the requester not granted last on a collision
    always_comb begin
        o_valid = |i_req;
        if (i_req == 2'b11) begin
            o_idx = ~r_last;
        end else if (i_req[1]) begin
            o_idx = 1'b1;
        end else begin
            o_idx = 1'b0;
        end
    end

    // Last-grant record; resets to 1 so requester 0 wins the first collision
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (i_update) begin
            r_last <= o_idx;
        end else begin
            r_last <= r_last;
        end
    end

endmodule

// File: rtl/mm2s_cmd_sched.sv
// -----------------------------------------------------------------------------
// mm2s_cmd_sched
// Arbitrates two loaders onto one AXI DataMover MM2S command channel, issues
// the command, then watches the MM2S data stream to detect the end of the
// transfer and flag length mismatches.
// Ports:
//   sys_clk, sys_rst             : clock, synchronous active-high reset
//   req[1:0]                     : per-requester request (0 param, 1 frame)
//   reqN_addr / reqN_btt         : start address / byte count, held with req
//   gnt[1:0]                     : one-cycle grant pulse
//   done[1:0]                    : one-cycle end-of-transfer pulse
//   err                          : one-cycle length-mismatch / zero-length
//   owner, busy                  : current owner, transfer in progress
//   m_axis_mm2s_cmd_*            : DataMover command stream (master)
//   s_axis_mm2s_tvalid/tready/tlast : monitored data handshake (input only)
// -----------------------------------------------------------------------------
module mm2s_cmd_sched
    import mm2s_cmd_sched_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int BTT_W  = 23
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [BTT_W-1:0]  req0_btt,
    input  logic [BTT_W-1:0]  req1_btt,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic              err,
    output logic              owner,
    output logic              busy,
    output logic              m_axis_mm2s_cmd_tvalid,
    input  logic              m_axis_mm2s_cmd_tready,
    output logic [CMD_W-1:0]  m_axis_mm2s_cmd_tdata,
    input  logic              s_axis_mm2s_tvalid,
    input  logic              s_axis_mm2s_tready,
    input  logic              s_axis_mm2s_tlast
);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [1:0]         r_gnt;
    logic [1:0]         r_done;
    logic               r_err;
    logic               r_owner;
    logic               r_busy;
    logic               r_cmd_tvalid;
    logic [CMD_W-1:0]   r_cmd_tdata;
    logic [BTT_W-1:0]   r_btt;
    logic [BTT_W-1:0]   r_cnt;
    logic [SEQ_W-1:0]   r_seq;

    logic [1:0]         w_gnt_nxt;
    logic [1:0]         w_done_nxt;
    logic               w_err_nxt;
    logic               w_busy_nxt;
    logic               w_cmd_tvalid_nxt;

    logic               w_arb_valid;
    logic               w_arb_idx;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [BTT_W-1:0]   w_sel_btt;
    logic               w_latch;
    logic               w_zero;
    logic               w_cmd_fire;
    logic               w_beat;
    logic               w_last;
    logic [BTT_W-1:0]   w_cnt_inc;

    rr_arb2 u_arb (
        .i_clk    (sys_clk),
        .i_rst    (sys_rst),
        .i_req    (req),
        .i_update (w_latch),
        .o_valid  (w_arb_valid),
        .o_idx    (w_arb_idx)
    );

    // Request selection and handshake qualifiers. A request is not taken
    // while a grant pulse is out: the requester only drops req in the cycle
    // after it sees gnt, so it would otherwise be granted twice.
    always_comb begin
        w_sel_addr = w_arb_idx ? req1_addr : req0_addr;
        w_sel_btt  = w_arb_idx ? req1_btt  : req0_btt;
        w_zero     = (w_sel_btt == {BTT_W{1'b0}});
        w_latch    = (r_state == ST_IDLE) && w_arb_valid && (r_gnt == 2'b00);
        w_cmd_fire = (r_state == ST_CMD) && r_cmd_tvalid && m_axis_mm2s_cmd_tready;
        w_beat     = (r_state == ST_DATA) && s_axis_mm2s_tvalid && s_axis_mm2s_tready;
        w_last     = w_beat && s_axis_mm2s_tlast;
        // Saturating increment; the tlast beat itself counts toward the total
        w_cnt_inc  = (r_cnt == {BTT_W{1'b1}}) ? r_cnt : (r_cnt + {{(BTT_W-1){1'b0}}, 1'b1});
    end

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_latch && !w_zero) begin
                    w_state_nxt = ST_CMD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (w_cmd_fire) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_CMD;
                end
            end
            ST_DATA: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered status outputs
    always_comb begin
        w_gnt_nxt        = 2'b00;
        w_done_nxt       = 2'b00;
        w_err_nxt        = 1'b0;
        w_busy_nxt       = r_busy;
        w_cmd_tvalid_nxt = r_cmd_tvalid;
        case (r_state)
            ST_IDLE: begin
                if (w_latch) begin
                    w_gnt_nxt[w_arb_idx] = 1'b1;
                    if (w_zero) begin
                        // Zero-length: acknowledge and fail immediately
                        w_done_nxt[w_arb_idx] = 1'b1;
                        w_err_nxt             = 1'b1;
                    end else begin
                        w_busy_nxt       = 1'b1;
                        w_cmd_tvalid_nxt = 1'b1;
                    end
                end else begin
                    w_busy_nxt       = 1'b0;
                    w_cmd_tvalid_nxt = 1'b0;
                end
            end
            ST_CMD: begin
                if (w_cmd_fire) begin
                    w_cmd_tvalid_nxt = 1'b0;
                end else begin
                    w_cmd_tvalid_nxt = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_last) begin
                    w_done_nxt[r_owner] = 1'b1;
                    w_err_nxt           = (w_cnt_inc != r_btt);
                    w_busy_nxt          = 1'b0;
                end else begin
                    w_busy_nxt          = 1'b1;
                end
            end
            default: begin
                w_busy_nxt       = 1'b0;
                w_cmd_tvalid_nxt = 1'b0;
            end
        endcase
    end

    // Registered status outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_gnt        <= 2'b00;
            r_done       <= 2'b00;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_cmd_tvalid <= 1'b0;
        end else begin
            r_gnt        <= w_gnt_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
            r_busy       <= w_busy_nxt;
            r_cmd_tvalid <= w_cmd_tvalid_nxt;
        end
    end

    // Transfer context: owner, length, command word, sequence and beat count
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_owner     <= 1'b0;
            r_btt       <= {BTT_W{1'b0}};
            r_cmd_tdata <= {CMD_W{1'b0}};
            r_seq       <= {SEQ_W{1'b0}};
            r_cnt       <= {BTT_W{1'b0}};
        end else begin
            if (w_latch) begin
                r_owner <= w_arb_idx;
                r_btt   <= w_sel_btt;
            end else begin
                r_owner <= r_owner;
                r_btt   <= r_btt;
            end
            // The command word is only reloaded when a command will be issued
            if (w_latch && !w_zero) begin
                r_cmd_tdata <= build_cmd(CMD_SADDR_W'(w_sel_addr),
                                         CMD_BTT_W'(w_sel_btt),
                                         {w_arb_idx, r_seq});
            end else begin
                r_cmd_tdata <= r_cmd_tdata;
            end
            if (w_cmd_fire) begin
                r_seq <= r_seq + 3'd1;
            end else begin
                r_seq <= r_seq;
            end
            if (w_latch || w_last) begin
                r_cnt <= {BTT_W{1'b0}};
            end else if (w_beat) begin
                r_cnt <= w_cnt_inc;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign gnt                    = r_gnt;
    assign done                   = r_done;
    assign err                    = r_err;
    assign owner                  = r_owner;
    assign busy                   = r_busy;
    assign m_axis_mm2s_cmd_tvalid = r_cmd_tvalid;
    assign m_axis_mm2s_cmd_tdata  = r_cmd_tdata;

endmodule
